// File: rtl/decode_stage_q_pkg.sv
// Shared types for the queued RV32I decode stage: opcodes, instruction
// formats and the decoded packet handed to the execute stage.
package decode_stage_q_pkg;

    typedef enum logic [6:0] {
        OP_LD    = 7'b0000011,
        OP_IMM   = 7'b0010011,
        OP_AUIPC = 7'b0010111,
        OP_ST    = 7'b0100011,
        OP_REG   = 7'b0110011,
        OP_LUI   = 7'b0110111,
        OP_BR    = 7'b1100011,
        OP_JALR  = 7'b1100111,
        OP_JAL   = 7'b1101111
    } rvga_opcode_e;

    typedef enum logic [2:0] {
        TYPE_R = 3'd0,
        TYPE_I = 3'd1,
        TYPE_S = 3'd2,
        TYPE_B = 3'd3,
        TYPE_U = 3'd4,
        TYPE_J = 3'd5,
        TYPE_E = 3'd6
    } rvga_inst_type_e;

    localparam logic [2:0] F3_ADDSUB = 3'd0;
    localparam logic [2:0] F3_SLL    = 3'd1;
    localparam logic [2:0] F3_SRX    = 3'd5;

    typedef struct packed {
        logic       rd_w_v;
        logic       dcache_w_v;
        logic       dcache_r_v;
        logic [2:0] funct3;
        logic       imm_v;
        logic       rs1_pc_sel;
        logic       imm_passthrough_v;
        logic       alt_art;
        logic       branch_v;
        logic       jump_v;
    } rvga_cword_s;

    typedef struct packed {
        logic [6:0]      opcode;
        rvga_inst_type_e inst_type;
        logic            illegal;
    } rvga_dword_s;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        rvga_cword_s cword;
        rvga_dword_s dword;
    } rvga_decode_pkt_s;

    // Sign-extend a 12-bit I/S-format immediate to 32 bits.
    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_q_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave = the decode stage itself, master = its surroundings.
interface decode_stage_q_if;
    import decode_stage_q_pkg::*;

    logic             ifetch_v_i;
    logic             ifetch_ready_o;
    logic [31:0]      ifetch_pc_i;
    logic [31:0]      ifetch_inst_i;
    logic             decode_v_o;
    logic             decode_ready_i;
    rvga_decode_pkt_s decode_pkt_o;

    modport slave (
        input  ifetch_v_i, ifetch_pc_i, ifetch_inst_i, decode_ready_i,
        output ifetch_ready_o, decode_v_o, decode_pkt_o
    );

    modport master (
        output ifetch_v_i, ifetch_pc_i, ifetch_inst_i, decode_ready_i,
        input  ifetch_ready_o, decode_v_o, decode_pkt_o
    );
endinterface

// File: rtl/decode_stage_q_fifo.sv
// Generic DEPTH-entry FIFO (rvga_fifo role): storage, wrapping pointers
// and occupancy count. DEPTH need not be a power of two. data_o is a
// registered copy of the head entry that keeps its value when empty.
module decode_stage_q_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [7:0]
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  T                           data_i,
    output T                           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    T              r_mem [DEPTH];
    T              r_head;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_rd_ptr_inc;
    logic [PW-1:0] w_wr_ptr_inc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign w_rd_ptr_inc = ptr_inc(r_rd_ptr);
    assign w_wr_ptr_inc = ptr_inc(r_wr_ptr);
    assign data_o       = r_head;
    assign count_o      = r_count;

    // Storage array, written at the write pointer; no reset so it maps to RAM.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers, count and head register; clear wins over push/pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (clr_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) r_wr_ptr <= w_wr_ptr_inc;
            if (pop_i)  r_rd_ptr <= w_rd_ptr_inc;
            if (push_i && !pop_i)      r_count <= r_count + 1'b1;
            else if (pop_i && !push_i) r_count <= r_count - 1'b1;
            // The incoming entry becomes head when the queue is (or is becoming) empty.
            if (push_i && ((r_count == '0) || (pop_i && (r_count == CW'(1)))))
                r_head <= data_i;
            else if (pop_i && (r_count > CW'(1)))
                r_head <= r_mem[w_rd_ptr_inc];
        end
    end
endmodule

// File: rtl/decode_stage_q.sv
// Queued RV32I decode stage: combinational decode of the fetch packet,
// written into a DEPTH-entry FIFO toward execute, with pipeline flush.
// Optional macro RVGA_DECODE_ILLEGAL_EN enables illegal-instruction marking.
module decode_stage_q
    import decode_stage_q_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    decode_stage_q_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]      w_inst;
    logic [2:0]       w_funct3;
    logic [31:0]      w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    rvga_decode_pkt_s w_dec;
    rvga_decode_pkt_s w_head;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count;
`ifdef RVGA_DECODE_ILLEGAL_EN
    logic [6:0]       w_funct7;
    logic             w_illegal;
    assign w_funct7 = w_inst[31:25];
`endif

    assign w_inst   = bus.ifetch_inst_i;
    assign w_funct3 = w_inst[14:12];
    assign w_imm_i  = sext12(w_inst[31:20]);
    assign w_imm_s  = sext12({w_inst[31:25], w_inst[11:7]});
    assign w_imm_b  = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u  = {w_inst[31:12], 12'b0};
    assign w_imm_j  = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    // Ready depends only on occupancy, never on the downstream ready.
    assign bus.ifetch_ready_o = !rst_i && (w_count < CW'(DEPTH));
    assign bus.decode_v_o     = (w_count != '0);
    assign bus.decode_pkt_o   = w_head;
    assign count_o            = w_count;
    assign w_push = bus.ifetch_v_i && bus.ifetch_ready_o && !flush_i;
    assign w_pop  = bus.decode_v_o && bus.decode_ready_i && !flush_i;

    // Decoder: field slicing, per-opcode control word and immediate selection.
    always_comb begin
        w_dec              = '0;
        w_dec.pc           = bus.ifetch_pc_i;
        w_dec.rs1          = w_inst[19:15];
        w_dec.rs2          = w_inst[24:20];
        w_dec.rd           = w_inst[11:7];
        w_dec.cword.funct3 = w_funct3;
        w_dec.dword.opcode = w_inst[6:0];
        w_dec.dword.inst_type = TYPE_E;
`ifdef RVGA_DECODE_ILLEGAL_EN
        w_illegal = 1'b0;
`endif
        case (w_inst[6:0])
            OP_LUI: begin
                w_dec.dword.inst_type = TYPE_U;
                w_dec.imm = w_imm_u;
                w_dec.cword.imm_v = 1'b1;
                w_dec.cword.rd_w_v = 1'b1;
                w_dec.cword.imm_passthrough_v = 1'b1;
            end
            OP_AUIPC: begin
                w_dec.dword.inst_type = TYPE_U;
                w_dec.imm = w_imm_u;
                w_dec.cword.imm_v = 1'b1;
                w_dec.cword.rd_w_v = 1'b1;
                w_dec.cword.rs1_pc_sel = 1'b1;
                w_dec.cword.funct3 = F3_ADDSUB;
            end
            OP_JAL: begin
                w_dec.dword.inst_type = TYPE_J;
                w_dec.imm = w_imm_j;
                w_dec.cword.imm_v = 1'b1;
                w_dec.cword.rd_w_v = 1'b1;
                w_dec.cword.jump_v = 1'b1;
                w_dec.cword.rs1_pc_sel = 1'b1;
            end
            OP_JALR: begin
                w_dec.dword.inst_type = TYPE_I;
                w_dec.imm = w_imm_i;
                w_dec.cword.imm_v = 1'b1;
                w_dec.cword.rd_w_v = 1'b1;
                w_dec.cword.jump_v = 1'b1;
`ifdef RVGA_DECODE_ILLEGAL_EN
                if (w_funct3 != 3'd0) w_illegal = 1'b1;
`endif
            end
            OP_BR: begin
                w_dec.dword.inst_type = TYPE_B;
                w_dec.imm = w_imm_b;
                w_dec.cword.imm_v = 1'b1;
                w_dec.cword.branch_v = 1'b1;
`ifdef RVGA_DECODE_ILLEGAL_EN
                if ((w_funct3 == 3'd2) || (w_funct3 == 3'd3)) w_illegal = 1'b1;
`endif
            end
            OP_LD: begin
                w_dec.dword.inst_type = TYPE_I;
                w_dec.imm = w_imm_i;
                w_dec.cword.imm_v = 1'b1;
                w_dec.cword.dcache_r_v = 1'b1;
                w_dec.cword.rd_w_v = 1'b1;
            end
            OP_ST: begin
                w_dec.dword.inst_type = TYPE_S;
                w_dec.imm = w_imm_s;
                w_dec.cword.imm_v = 1'b1;
                w_dec.cword.dcache_w_v = 1'b1;
            end
            OP_IMM: begin
                w_dec.dword.inst_type = TYPE_I;
                // Shift-immediates carry only a 5-bit shamt; inst[30] selects arithmetic.
                if ((w_funct3 == F3_SLL) || (w_funct3 == F3_SRX))
                    w_dec.imm = {27'b0, w_inst[24:20]};
                else
                    w_dec.imm = w_imm_i;
                w_dec.cword.imm_v = 1'b1;
                w_dec.cword.rd_w_v = 1'b1;
                w_dec.cword.alt_art = (w_funct3 == F3_SRX) && w_inst[30];
`ifdef RVGA_DECODE_ILLEGAL_EN
                if ((w_funct3 == F3_SLL) && (w_funct7 != 7'h00)) w_illegal = 1'b1;
                if ((w_funct3 == F3_SRX) && (w_funct7 != 7'h00) && (w_funct7 != 7'h20)) w_illegal = 1'b1;
`endif
            end
            OP_REG: begin
                w_dec.dword.inst_type = TYPE_R;
                w_dec.cword.rd_w_v = 1'b1;
                w_dec.cword.alt_art = ((w_funct3 == F3_SRX) || (w_funct3 == F3_ADDSUB)) && w_inst[30];
`ifdef RVGA_DECODE_ILLEGAL_EN
                if ((w_funct7 != 7'h00) && (w_funct7 != 7'h20)) w_illegal = 1'b1;
                if ((w_funct7 == 7'h20) && (w_funct3 != F3_ADDSUB) && (w_funct3 != F3_SRX)) w_illegal = 1'b1;
`endif
            end
            default: begin
`ifdef RVGA_DECODE_ILLEGAL_EN
                w_illegal = 1'b1;
`endif
            end
        endcase
`ifdef RVGA_DECODE_ILLEGAL_EN
        // An illegal instruction must not cause any architectural side effect.
        if (w_illegal) begin
            w_dec.cword.rd_w_v = 1'b0;
            w_dec.cword.dcache_w_v = 1'b0;
            w_dec.cword.dcache_r_v = 1'b0;
            w_dec.cword.imm_v = 1'b0;
            w_dec.cword.rs1_pc_sel = 1'b0;
            w_dec.cword.imm_passthrough_v = 1'b0;
            w_dec.cword.alt_art = 1'b0;
            w_dec.cword.branch_v = 1'b0;
            w_dec.cword.jump_v = 1'b0;
        end
        w_dec.dword.illegal = w_illegal;
`endif
    end

    decode_stage_q_fifo #(
        .DEPTH (DEPTH),
        .T     (rvga_decode_pkt_s)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (flush_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (w_dec),
        .data_o  (w_head),
        .count_o (w_count)
    );
endmodule

// File: tb/tb_decode_stage_q.sv
// Scoreboard bench for decode_stage_q (DEPTH=2): directed instructions,
// full-queue backpressure, flush and asynchronous reset.
module tb_decode_stage_q;
    import decode_stage_q_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] count;

    decode_stage_q_if bus();

    decode_stage_q #(.DEPTH(2)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus),
        .count_o (count)
    );

    always #5 clk = ~clk;

`ifdef RVGA_DECODE_ILLEGAL_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    rvga_decode_pkt_s sb[$];
    rvga_decode_pkt_s e_addi, e_lui, e_beq, e_jal, e_srai, e_sw, e_zero, e_sub, zero_pkt;

    // fl = {rd_w_v, dcache_w_v, dcache_r_v, imm_v, rs1_pc_sel, imm_passthrough_v, alt_art, branch_v, jump_v}
    function automatic rvga_decode_pkt_s mk(input logic [4:0] rs1, input logic [4:0] rs2,
            input logic [4:0] rd, input logic [31:0] imm, input logic [2:0] f3,
            input logic [8:0] fl, input logic [6:0] op, input rvga_inst_type_e ty, input logic ill);
        rvga_decode_pkt_s p;
        p = '0;
        p.rs1 = rs1; p.rs2 = rs2; p.rd = rd; p.imm = imm;
        p.cword.funct3 = f3;
        {p.cword.rd_w_v, p.cword.dcache_w_v, p.cword.dcache_r_v, p.cword.imm_v,
         p.cword.rs1_pc_sel, p.cword.imm_passthrough_v, p.cword.alt_art,
         p.cword.branch_v, p.cword.jump_v} = fl;
        p.dword.opcode = op;
        p.dword.inst_type = ty;
        p.dword.illegal = ill;
        return p;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    // Pops the scoreboard whenever the DUT hands over its head entry.
    task automatic monitor();
        rvga_decode_pkt_s e;
        forever begin
            @(negedge clk);
            if (!rst && bus.decode_v_o && bus.decode_ready_i && !flush) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pop_unexpected got pc=%0h expected no output", bus.decode_pkt_o.pc);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("pkt pc=%0h", e.pc), bus.decode_pkt_o, e);
                end
            end
        end
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] inst, input rvga_decode_pkt_s exp);
        int n;
        rvga_decode_pkt_s e;
        @(posedge clk); #1;
        bus.ifetch_v_i = 1'b1;
        bus.ifetch_pc_i = pc;
        bus.ifetch_inst_i = inst;
        n = 0;
        while (!bus.ifetch_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (!bus.ifetch_ready_o) begin
            fails++;
            $display("FAIL send_timeout pc=%0h got ready=0 expected ready=1", pc);
            bus.ifetch_v_i = 1'b0;
        end else begin
            e = exp;
            e.pc = pc;
            sb.push_back(e);
            @(posedge clk); #1;
            bus.ifetch_v_i = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_left", 128'(sb.size()), 128'd0);
        chk("drain_count", 128'(count), 128'd0);
    endtask

    initial begin
        e_addi = mk(5'd2, 5'd31, 5'd1,  32'hFFFFFFFF, 3'd0, 9'b100100000, 7'h13, TYPE_I, 1'b0);
        e_lui  = mk(5'd8, 5'd3,  5'd5,  32'h12345000, 3'd5, 9'b100101000, 7'h37, TYPE_U, 1'b0);
        e_beq  = mk(5'd0, 5'd0,  5'd29, 32'hFFFFFFFC, 3'd0, 9'b000100010, 7'h63, TYPE_B, 1'b0);
        e_jal  = mk(5'd0, 5'd8,  5'd1,  32'h00000008, 3'd0, 9'b100110001, 7'h6F, TYPE_J, 1'b0);
        e_srai = mk(5'd4, 5'd5,  5'd3,  32'h00000005, 3'd5, 9'b100100100, 7'h13, TYPE_I, 1'b0);
        e_sw   = mk(5'd2, 5'd5,  5'd12, 32'h0000000C, 3'd2, 9'b010100000, 7'h23, TYPE_S, 1'b0);
        e_zero = mk(5'd0, 5'd0,  5'd0,  32'h0,        3'd0, 9'b000000000, 7'h00, TYPE_E, ILL);
        e_sub  = mk(5'd1, 5'd2,  5'd0,  32'h0,        3'd0, ILL ? 9'b000000000 : 9'b100000000,
                    7'h33, TYPE_R, ILL);
        zero_pkt = '0;

        rst = 1'b1;
        flush = 1'b0;
        bus.ifetch_v_i = 1'b0;
        bus.ifetch_pc_i = '0;
        bus.ifetch_inst_i = '0;
        bus.decode_ready_i = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_valid", 128'(bus.decode_v_o), 128'd0);
        chk("rst_ready", 128'(bus.ifetch_ready_o), 128'd0);
        chk("rst_pkt", 128'(bus.decode_pkt_o), 128'(zero_pkt));
        rst = 1'b0;
        #1;
        chk("rel_ready", 128'(bus.ifetch_ready_o), 128'd1);

        // Decode vectors with execute always ready
        bus.decode_ready_i = 1'b1;
        send(32'h100, 32'hFFF10093, e_addi);
        chk("lat_valid", 128'(bus.decode_v_o), 128'd1);
        send(32'h104, 32'h123452B7, e_lui);
        send(32'h108, 32'hFE000EE3, e_beq);
        send(32'h10C, 32'h008000EF, e_jal);
        send(32'h110, 32'h40525193, e_srai);
        send(32'h114, 32'h00512623, e_sw);
        send(32'h118, 32'h00000000, e_zero);
        send(32'h11C, 32'h80208033, e_sub);
        drain();

        // Full queue refuses input until an entry leaves
        bus.decode_ready_i = 1'b0;
        send(32'h200, 32'hFFF10093, e_addi);
        send(32'h204, 32'h123452B7, e_lui);
        @(posedge clk); #1;
        bus.ifetch_v_i = 1'b1;
        bus.ifetch_pc_i = 32'h208;
        bus.ifetch_inst_i = 32'hFE000EE3;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("full_ready", 128'(bus.ifetch_ready_o), 128'd0);
        chk("full_count", 128'(count), 128'd2);
        bus.decode_ready_i = 1'b1;
        send(32'h208, 32'hFE000EE3, e_beq);
        drain();

        // Flush discards queued entries and the incoming packet
        bus.decode_ready_i = 1'b0;
        send(32'h300, 32'h008000EF, e_jal);
        send(32'h304, 32'h00512623, e_sw);
        chk("pre_flush_count", 128'(count), 128'd2);
        @(posedge clk); #1;
        flush = 1'b1;
        bus.ifetch_v_i = 1'b1;
        bus.ifetch_pc_i = 32'h3FC;
        bus.ifetch_inst_i = 32'hFFF10093;
        sb.delete();
        @(posedge clk); #1;
        chk("flush_count", 128'(count), 128'd0);
        chk("flush_valid", 128'(bus.decode_v_o), 128'd0);
        @(posedge clk); #1;
        chk("flush_drop_in", 128'(count), 128'd0);
        flush = 1'b0;
        bus.ifetch_v_i = 1'b0;
        bus.decode_ready_i = 1'b1;
        send(32'h400, 32'h40525193, e_srai);
        drain();

        // Asynchronous reset in the middle of a cycle
        bus.decode_ready_i = 1'b0;
        send(32'h500, 32'hFFF10093, e_addi);
        send(32'h504, 32'h123452B7, e_lui);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 128'(count), 128'd0);
        chk("arst_valid", 128'(bus.decode_v_o), 128'd0);
        chk("arst_ready", 128'(bus.ifetch_ready_o), 128'd0);
        chk("arst_pkt", 128'(bus.decode_pkt_o), 128'(zero_pkt));
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("arst_rel_ready", 128'(bus.ifetch_ready_o), 128'd1);
        bus.decode_ready_i = 1'b1;
        send(32'h600, 32'h00000000, e_zero);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decode_stage_q.md
# decode_stage_q

Parametrised successor to the single-register decode stage. It decodes the full RV32I base control-flow set (adds JAL, JALR and complete branch/jump immediates) and adds ready/valid handshakes on both sides with a DEPTH-entry output queue. It also supports a pipeline flush and optional illegal-instruction detection. It sits between the ifetch stage and the execute stage.

## Interface
- DEPTH, 2, output queue entries (≥1).
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  discard queue contents and the current input.
- ifetch_v_i  in  1  fetch packet valid.
- ifetch_ready_o  out  1  stage can accept a packet.
- ifetch_pc_i  in  32  packet PC.
- ifetch_inst_i  in  32  packet instruction.
- decode_v_o  out  1  head entry valid.
- decode_ready_i  in  1  execute consumes the head entry.
- decode_pkt_o  out  rvga_decode_pkt_s  head entry contents:
  - pc, rs1, rs2, rd, imm.
  - cword: rd_w_v, dcache_w_v, dcache_r_v, funct3, imm_v, rs1_pc_sel, imm_passthrough_v, alt_art, branch_v, jump_v.
  - dword: opcode, inst_type, illegal.
- count_o  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Accept when ifetch_v_i && ifetch_ready_o && !flush_i.
- Pop when decode_v_o && decode_ready_i && !flush_i.
- ifetch_ready_o = !rst_i && count < DEPTH. It does not depend combinationally on decode_ready_i, so a full queue refuses input even if it pops that cycle.
- decode_v_o = count != 0.
- Entries leave in FIFO order. pkt_o shows the head entry. When empty, pkt_o holds its last value, or zero after reset.
- Decode is combinational on ifetch_inst_i and is written into the queue on accept. Field slices: rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7], opcode[6:0].
- Per-opcode control:
  - lui 0110111: U-type, imm_v, rd_w_v, imm_passthrough_v.
  - auipc 0010111: U-type, imm_v, rd_w_v, rs1_pc_sel, funct3 forced to addsub.
  - jal 1101111: J-type, imm_v, rd_w_v, jump_v, rs1_pc_sel.
  - jalr 1100111: I-type, imm_v, rd_w_v, jump_v.
  - br 1100011: B-type, imm_v, branch_v.
  - ld 0000011: I-type, imm_v, dcache_r_v, rd_w_v.
  - st 0100011: S-type, imm_v, dcache_w_v.
  - imm 0010011: I-type, imm_v, rd_w_v; alt_art = inst[30] for srx.
  - reg 0110011: R-type, rd_w_v; alt_art = inst[30] for srx and addsub.
  - anything else: type e, all enables 0.
- Immediates, sign-extended from inst[31]:
  - I: inst[31:20].
  - I shifts (imm opcode with funct3 sll/srx): {27'b0, inst[24:20]}.
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - R and e: 0.
- Flush has priority over accept and pop. Count, read pointer and write pointer go to 0 at the edge, and ifetch_v_i in the flush cycle is dropped.

## Timing
- Latency: a packet accepted at edge N is visible on decode_v_o/pkt_o after edge N. A packet popped at edge N is removed at edge N.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Push to an empty queue while decode_ready_i is high: no pop that cycle, since decode_v_o is low. The entry appears next cycle.
- Pointers wrap modulo DEPTH, and DEPTH need not be a power of two.
- Reset, including assertion mid-operation: count_o=0, decode_v_o=0, pkt_o=0, pointers=0, ifetch_ready_o=0 while rst_i is high. ifetch_ready_o rises combinationally on deassertion.

## Configuration
- RVGA_DECODE_ILLEGAL_EN defined: dword.illegal=1 for any of the following, and such entries keep all enables 0:
  - unknown opcode;
  - reg opcode with funct7 ∉ {0x00, 0x20}, or 0x20 with funct3 ∉ {addsub, srx};
  - imm slli with funct7 ≠ 0, or srxi with funct7 ∉ {0x00, 0x20};
  - br funct3 ∈ {2, 3};
  - jalr funct3 ≠ 0.
- Undefined: dword.illegal is tied 0 and no funct7 checks are made.

## Structure
- rvga_types gains:
  - opcode enumerators jal/jalr;
  - rvga_decode_pkt_s;
  - the new cword fields branch_v and jump_v;
  - dword.illegal.
- Sub-module rvga_fifo holds storage, pointers and count. It is parametrised by DEPTH and element type and is reusable for ifetch buffering. The decoder stays in this module as one always_comb.

## Test plan
- addi x1,x2,-1 (0xFFF10093), ready high → next cycle rs1=2, rd=1, imm=0xFFFFFFFF, imm_v=1, rd_w_v=1.
- lui x5,0x12345 (0x123452B7) → imm=0x12345000, imm_passthrough_v=1; beq x0,x0,-4 (0xFE000EE3) → imm=0xFFFFFFFC, branch_v=1; jal x1,+8 (0x008000EF) → imm=8, jump_v=1.
- DEPTH=2, decode_ready_i=0, stream three packets → ifetch_ready_o low after 2 accepts. Raise ready → packets emerge in PC order and the third is accepted once ready returns.
- Fill with 2 entries, assert flush_i with ifetch_v_i high → next cycle count_o=0, decode_v_o=0, and the flushed input is never emitted.
- With the macro defined: 0x00000000 → illegal=1, all enables 0; sub with funct7 0x40 (0x80208033) → illegal=1. Without the macro: illegal=0.
- rst_i asserted mid-stream asynchronously, with no clock edge → count_o=0, decode_v_o=0, ifetch_ready_o=0 immediately.
